instr_stream_encoder: RTL and testbench
=======================================

# instr_stream_encoder

Program-loader block for the single-cycle LEGv8 CPU. It is the encode-side counterpart of the control-path decoder. It accepts symbolic instructions (mnemonic code plus register and immediate fields) over a valid/ready handshake, packs each one into a 32-bit LEGv8 word, and buffers the words in a small FIFO. It then writes them to consecutive instruction-memory word addresses starting at a programmed base.

## Interface
- ADDR_WIDTH, 10, instruction-memory word-address width
- FIFO_DEPTH, 4, encoded-word buffer entries (power of 2, ≥2)

- clk  in  1  clock; all state updates on rising edge
- reset  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse; latches baseAddr, begins a load session (honoured in IDLE only)
- baseAddr  in  ADDR_WIDTH  first write address of the session
- inValid  in  1  instruction fields valid
- inReady  out  1  encoder can accept this cycle
- inOp  in  4  0 ADDI, 1 ADDS, 2 SUBS, 3 B, 4 BL, 5 B.LT, 6 CBZ, 7 BR, 8 LDUR, 9 STUR, 10–15 illegal
- inRd  in  5  Rd/Rt
- inRn  in  5  Rn
- inRm  in  5  Rm
- inImm  in  26  immediate/offset, two's complement
- inLast  in  1  final instruction of session
- imemWe  out  1  write request
- imemReady  in  1  memory accepts write this cycle
- imemAddr  out  ADDR_WIDTH  write word address
- imemData  out  32  encoded word
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at session end
- errIllegal  out  1  sticky; illegal inOp accepted
- errRange  out  1  sticky; immediate overflowed its field (see Configuration)

## Operation
- Encodings (bit ranges):
  - ADDI: 1001000100[31:22], imm12[21:10], Rn, Rd.
  - ADDS/SUBS: 10101011000/11101011000[31:21], Rm[20:16], 000000[15:10], Rn[9:5], Rd[4:0].
  - B/BL: 000101/100101[31:26], imm26.
  - B.LT: 01010100[31:24], imm19[23:5], 01011[4:0].
  - CBZ: 10110100, imm19, Rd as Rt.
  - BR: 11010110000, 11111, 000000, Rn, 00000.
  - LDUR/STUR: 11111000010/11111000000, dAddr9[20:12], 00[11:10], Rn, Rt.
- Fields are taken from the low bits of inImm; unused inputs are ignored.
- FSM:
  - IDLE: start → RUN; imemAddr←baseAddr; errIllegal and errRange cleared.
  - RUN: accept when inValid&&inReady. An accept with inLast sets lastSeen.
  - RUN → DONE when lastSeen, FIFO empty, and no write pending.
  - DONE: done=1 for one cycle → IDLE.
- Legal op: encoded word pushed to FIFO on the accept edge.
- Illegal op: accepted and dropped (no push, address unchanged), errIllegal←1. If it carries inLast, it still ends the session.
- Write: imemWe=!empty in RUN. On imemWe&&imemReady, pop and imemAddr+1. Address wraps 2^ADDR_WIDTH−1→0 silently.
- start while RUN/DONE is ignored.

## Timing
- Reset values: inReady 0, imemWe 0, imemAddr 0, imemData 0, busy 0, done 0, errIllegal 0, errRange 0. FSM goes to IDLE; FIFO is emptied and lastSeen cleared.
- Reset mid-session aborts immediately; buffered words are discarded.
- inReady = RUN && !full && !lastSeen, registered-state only. It does not count a same-cycle pop.
- Latency: accept at edge N → imemWe=1 with that word during cycle N+1 (empty FIFO).
- imemData and imemAddr are held stable while imemWe&&!imemReady.
- Throughput is one word/cycle with imemReady=1. Simultaneous push and pop is legal at any occupancy except a push when full, which cannot occur.
- done asserts the cycle after the final write handshake. busy drops with done.

## Configuration
- ENC_RANGE_CHECK_EN defined:
  - Check ADDI imm unsigned <4096.
  - Check dAddr9 signed −256..255, imm19 signed −2^18..2^18−1, and imm26 full width.
  - An out-of-range value sets errRange. The truncated word is still written.
- Undefined: silent truncation; errRange is tied 0.

## Test plan
- start, baseAddr 0, ADDI Rd1 Rn2 imm5, inLast → addr 0 ← 0x91001441, done one cycle later, busy 0.
- ADDS Rd3 Rn1 Rm2; B imm −1; B.LT imm 2; LDUR Rt5 Rn6 imm8 → 0xAB020023, 0x17FFFFFF, 0x5400004B, 0xF84080C5 at addr 0..3.
- imemReady 0 for 8 cycles while 6 ops are offered → exactly FIFO_DEPTH accepts, inReady 0; after release, all 6 words written in order with no loss.
- baseAddr 1022 (ADDR_WIDTH 10), 4 ops → writes at 1022, 1023, 0, 1.
- inOp 12 between two ADDIs → two writes at consecutive addresses, errIllegal 1 until next start.
- With ENC_RANGE_CHECK_EN: ADDI imm 4096 → errRange 1, word 0x91000000|regs; without macro errRange stays 0. Reset asserted mid-session → all outputs return to reset values the same cycle.

Source files
------------

// File: rtl/instr_stream_encoder.sv
// LEGv8 program loader: packs symbolic instructions into 32-bit words, buffers them,
// and streams them to instruction memory. Define ENC_RANGE_CHECK_EN to flag immediate overflow.
module instr_stream_encoder #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  start,
  input  logic [ADDR_WIDTH-1:0] baseAddr,
  input  logic                  inValid,
  output logic                  inReady,
  input  logic [3:0]            inOp,
  input  logic [4:0]            inRd,
  input  logic [4:0]            inRn,
  input  logic [4:0]            inRm,
  input  logic [25:0]           inImm,
  input  logic                  inLast,
  output logic                  imemWe,
  input  logic                  imemReady,
  output logic [ADDR_WIDTH-1:0] imemAddr,
  output logic [31:0]           imemData,
  output logic                  busy,
  output logic                  done,
  output logic                  errIllegal,
  output logic                  errRange
);

  localparam int unsigned PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CNT_W = PTR_W + 1;

  localparam logic [3:0] OP_ADDI = 4'd0;
  localparam logic [3:0] OP_ADDS = 4'd1;
  localparam logic [3:0] OP_SUBS = 4'd2;
  localparam logic [3:0] OP_B    = 4'd3;
  localparam logic [3:0] OP_BL   = 4'd4;
  localparam logic [3:0] OP_BLT  = 4'd5;
  localparam logic [3:0] OP_CBZ  = 4'd6;
  localparam logic [3:0] OP_BR   = 4'd7;
  localparam logic [3:0] OP_LDUR = 4'd8;
  localparam logic [3:0] OP_STUR = 4'd9;

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  state_t             state, state_n;
  logic [CNT_W-1:0]   count, count_n;
  logic [PTR_W-1:0]   rd_ptr, rd_n, wr_ptr, wr_n;
  logic               last_seen, last_n;
  logic [31:0]        mem [FIFO_DEPTH];
  logic [31:0]        head_n;
  logic [31:0]        enc_word;
  logic               enc_legal;
  logic               accept, push, pop;

  // Instruction packing; fields come from the low bits of the inputs
  always_comb begin
    enc_word  = '0;
    enc_legal = 1'b1;
    case (inOp)
      OP_ADDI: enc_word = {10'b1001000100, inImm[11:0], inRn, inRd};
      OP_ADDS: enc_word = {11'b10101011000, inRm, 6'b000000, inRn, inRd};
      OP_SUBS: enc_word = {11'b11101011000, inRm, 6'b000000, inRn, inRd};
      OP_B:    enc_word = {6'b000101, inImm};
      OP_BL:   enc_word = {6'b100101, inImm};
      OP_BLT:  enc_word = {8'b01010100, inImm[18:0], 5'b01011};
      OP_CBZ:  enc_word = {8'b10110100, inImm[18:0], inRd};
      OP_BR:   enc_word = {11'b11010110000, 5'b11111, 6'b000000, inRn, 5'b00000};
      OP_LDUR: enc_word = {11'b11111000010, inImm[8:0], 2'b00, inRn, inRd};
      OP_STUR: enc_word = {11'b11111000000, inImm[8:0], 2'b00, inRn, inRd};
      default: enc_legal = 1'b0;
    endcase
  end

`ifdef ENC_RANGE_CHECK_EN
  logic enc_range_bad;

  // Signed fields fit when all bits above the field match its sign bit
  always_comb begin
    enc_range_bad = 1'b0;
    case (inOp)
      OP_ADDI:          enc_range_bad = |inImm[25:12];
      OP_BLT, OP_CBZ:   enc_range_bad = !((&inImm[25:18]) || !(|inImm[25:18]));
      OP_LDUR, OP_STUR: enc_range_bad = !((&inImm[25:8]) || !(|inImm[25:8]));
      default:          enc_range_bad = 1'b0;
    endcase
  end
`endif

  assign accept = inValid && inReady;
  assign push   = accept && enc_legal;
  assign pop    = imemWe && imemReady;

  // Next-state view so every output can be registered from it
  always_comb begin
    state_n = state;
    last_n  = last_seen;
    count_n = count + CNT_W'(push) - CNT_W'(pop);
    rd_n    = rd_ptr + PTR_W'(pop);
    wr_n    = wr_ptr + PTR_W'(push);
    head_n  = (push && (rd_n == wr_ptr)) ? enc_word : mem[rd_n];
    case (state)
      IDLE: begin
        if (start) begin
          state_n = RUN;
          last_n  = 1'b0;
        end
      end
      RUN: begin
        if (accept && inLast) last_n = 1'b1;
        if (last_n && (count_n == '0)) state_n = DONE;
      end
      DONE: begin
        state_n = IDLE;
        last_n  = 1'b0;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      count      <= '0;
      rd_ptr     <= '0;
      wr_ptr     <= '0;
      last_seen  <= 1'b0;
      inReady    <= 1'b0;
      imemWe     <= 1'b0;
      imemAddr   <= '0;
      imemData   <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      errIllegal <= 1'b0;
      errRange   <= 1'b0;
    end else begin
      state     <= state_n;
      count     <= count_n;
      rd_ptr    <= rd_n;
      wr_ptr    <= wr_n;
      last_seen <= last_n;
      inReady   <= (state_n == RUN) && (count_n != CNT_W'(FIFO_DEPTH)) && !last_n;
      imemWe    <= (state_n == RUN) && (count_n != '0);
      busy      <= (state_n != IDLE);
      done      <= (state_n == DONE);
      if (count_n != '0) imemData <= head_n;
      if ((state == IDLE) && start) begin
        imemAddr   <= baseAddr;
        errIllegal <= 1'b0;
`ifdef ENC_RANGE_CHECK_EN
        errRange   <= 1'b0;
`endif
      end else begin
        if (pop) imemAddr <= imemAddr + ADDR_WIDTH'(1);
        if (accept && !enc_legal) errIllegal <= 1'b1;
`ifdef ENC_RANGE_CHECK_EN
        if (push && enc_range_bad) errRange <= 1'b1;
`endif
      end
`ifndef ENC_RANGE_CHECK_EN
      errRange <= 1'b0;
`endif
    end
  end

endmodule

// File: tb/tb_instr_stream_encoder.sv
// Bench for instr_stream_encoder: vector table plus scoreboard of expected memory writes.
module tb_instr_stream_encoder;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  baseAddr;
  logic        inValid;
  logic        inReady;
  logic [3:0]  inOp;
  logic [4:0]  inRd, inRn, inRm;
  logic [25:0] inImm;
  logic        inLast;
  logic        imemWe;
  logic        imemReady;
  logic [9:0]  imemAddr;
  logic [31:0] imemData;
  logic        busy, done, errIllegal, errRange;

`ifdef ENC_RANGE_CHECK_EN
  localparam logic EXP_RANGE = 1'b1;
`else
  localparam logic EXP_RANGE = 1'b0;
`endif

  instr_stream_encoder #(.ADDR_WIDTH(10), .FIFO_DEPTH(4)) dut (
    .clk(clk), .reset(reset), .start(start), .baseAddr(baseAddr),
    .inValid(inValid), .inReady(inReady), .inOp(inOp), .inRd(inRd),
    .inRn(inRn), .inRm(inRm), .inImm(inImm), .inLast(inLast),
    .imemWe(imemWe), .imemReady(imemReady), .imemAddr(imemAddr),
    .imemData(imemData), .busy(busy), .done(done),
    .errIllegal(errIllegal), .errRange(errRange)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  op;
    logic [4:0]  rd, rn, rm;
    logic [25:0] imm;
    logic [31:0] word;
    logic        legal;
  } vec_t;

  typedef struct {
    logic [9:0]  addr;
    logic [31:0] data;
  } wr_t;

  vec_t  tbl [10];
  vec_t  v_illegal, v_range;
  wr_t   q [$];
  logic [9:0] exp_addr;
  int    checks = 0;
  int    errors = 0;
  int    cyc = 0;
  int    last_wr_cyc = -10;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic drive(input vec_t v, input logic last);
    inValid = 1'b1;
    inOp = v.op; inRd = v.rd; inRn = v.rn; inRm = v.rm; inImm = v.imm;
    inLast = last;
  endtask

  task automatic expect_word(input vec_t v);
    if (v.legal) begin
      q.push_back('{addr: exp_addr, data: v.word});
      exp_addr = exp_addr + 10'd1;
    end
  endtask

  // Called and returns at posedge+1
  task automatic send(input vec_t v, input logic last);
    int n = 0;
    drive(v, last);
    forever begin
      @(negedge clk);
      if (inReady) break;
      n++;
      if (n > 200) begin
        chk("send_timeout", 32'(inReady), 32'd1);
        break;
      end
    end
    if (inReady) expect_word(v);
    @(posedge clk); #1;
    inValid = 1'b0;
    inLast = 1'b0;
  endtask

  task automatic start_sess(input logic [9:0] base);
    start = 1'b1;
    baseAddr = base;
    exp_addr = base;
    @(posedge clk); #1;
    start = 1'b0;
    @(negedge clk);
    chk("busy_in_session", 32'(busy), 32'd1);
    chk("ready_at_start", 32'(inReady), 32'd1);
    chk("errIllegal_cleared", 32'(errIllegal), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic wait_done(input logic timing);
    int n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!done && n < 200);
    chk("done_seen", 32'(done), 32'd1);
    chk("all_writes_seen", 32'(q.size()), 32'd0);
    if (timing) chk("done_after_last_write", 32'(cyc), 32'(last_wr_cyc + 1));
    @(negedge clk);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("busy_after_done", 32'(busy), 32'd0);
    @(posedge clk); #1;
  endtask

  task automatic chk_reset_outputs();
    chk("rst_inReady", 32'(inReady), 32'd0);
    chk("rst_imemWe", 32'(imemWe), 32'd0);
    chk("rst_imemAddr", 32'(imemAddr), 32'd0);
    chk("rst_imemData", imemData, 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_errIllegal", 32'(errIllegal), 32'd0);
    chk("rst_errRange", 32'(errRange), 32'd0);
  endtask

  initial begin
    int idx;
    int acc;
    logic got;
    wr_t w;

    tbl[0] = '{op: 4'd0, rd: 5'd1, rn: 5'd2, rm: 5'd0, imm: 26'd5,        word: 32'h91001441, legal: 1'b1};
    tbl[1] = '{op: 4'd1, rd: 5'd3, rn: 5'd1, rm: 5'd2, imm: 26'd0,        word: 32'hAB020023, legal: 1'b1};
    tbl[2] = '{op: 4'd3, rd: 5'd0, rn: 5'd0, rm: 5'd0, imm: 26'h3FFFFFF,  word: 32'h17FFFFFF, legal: 1'b1};
    tbl[3] = '{op: 4'd5, rd: 5'd0, rn: 5'd0, rm: 5'd0, imm: 26'd2,        word: 32'h5400004B, legal: 1'b1};
    tbl[4] = '{op: 4'd8, rd: 5'd5, rn: 5'd6, rm: 5'd0, imm: 26'd8,        word: 32'hF84080C5, legal: 1'b1};
    tbl[5] = '{op: 4'd2, rd: 5'd4, rn: 5'd5, rm: 5'd6, imm: 26'd0,        word: 32'hEB0600A4, legal: 1'b1};
    tbl[6] = '{op: 4'd4, rd: 5'd0, rn: 5'd0, rm: 5'd0, imm: 26'h100,      word: 32'h94000100, legal: 1'b1};
    tbl[7] = '{op: 4'd6, rd: 5'd7, rn: 5'd0, rm: 5'd0, imm: 26'h3FFFFFE,  word: 32'hB4FFFFC7, legal: 1'b1};
    tbl[8] = '{op: 4'd7, rd: 5'd0, rn: 5'd30, rm: 5'd0, imm: 26'd0,       word: 32'hD61F03C0, legal: 1'b1};
    tbl[9] = '{op: 4'd9, rd: 5'd2, rn: 5'd3, rm: 5'd0, imm: 26'h3FFFFFC,  word: 32'hF81FC062, legal: 1'b1};
    v_illegal = '{op: 4'd12, rd: 5'd9, rn: 5'd9, rm: 5'd9, imm: 26'd1,    word: 32'h0, legal: 1'b0};
    v_range   = '{op: 4'd0, rd: 5'd1, rn: 5'd2, rm: 5'd0, imm: 26'd4096,  word: 32'h91000041, legal: 1'b1};

    reset = 1'b0; start = 1'b0; baseAddr = '0; inValid = 1'b0;
    inOp = '0; inRd = '0; inRn = '0; inRm = '0; inImm = '0; inLast = 1'b0;
    imemReady = 1'b1; exp_addr = '0;

    // Scoreboard: every memory handshake must match the head of the queue
    fork
      forever begin
        @(posedge clk);
        cyc++;
      end
      forever begin
        @(negedge clk);
        if (reset && imemWe && imemReady) begin
          last_wr_cyc = cyc;
          if (q.size() == 0) begin
            chk("unexpected_write_addr", 32'(imemAddr), 32'hFFFFFFFF);
          end else begin
            w = q.pop_front();
            chk("write_addr", 32'(imemAddr), 32'(w.addr));
            chk("write_data", imemData, w.data);
          end
        end
      end
    join_none

    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    reset = 1'b1;
    @(posedge clk); #1;

    // Single ADDI session
    start_sess(10'd0);
    send(tbl[0], 1'b1);
    wait_done(1'b1);

    // All opcodes from the table, back to back
    start_sess(10'd0);
    for (int i = 1; i < 10; i++) send(tbl[i], i == 9);
    wait_done(1'b1);
    chk("errRange_in_range", 32'(errRange), 32'd0);
    chk("errIllegal_none", 32'(errIllegal), 32'd0);

    // Memory stalled while six ops are offered: only FIFO_DEPTH accepted
    imemReady = 1'b0;
    start_sess(10'h20);
    idx = 0;
    acc = 0;
    drive(tbl[0], 1'b0);
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      got = inReady && inValid;
      if (got) begin
        expect_word(tbl[idx]);
        acc++;
      end
      @(posedge clk); #1;
      if (got) begin
        idx++;
        drive(tbl[idx], 1'b0);
      end
    end
    @(negedge clk);
    chk("stall_accepts", 32'(acc), 32'd4);
    chk("stall_inReady", 32'(inReady), 32'd0);
    chk("stall_imemWe", 32'(imemWe), 32'd1);
    chk("stall_addr_held", 32'(imemAddr), 32'h20);
    chk("stall_data_held", imemData, tbl[0].word);
    @(posedge clk); #1;
    imemReady = 1'b1;
    for (int i = idx; i < 6; i++) send(tbl[i], i == 5);
    wait_done(1'b1);

    // Address wrap at the top of memory
    start_sess(10'd1022);
    for (int i = 0; i < 4; i++) send(tbl[i], i == 3);
    wait_done(1'b1);

    // Illegal op in the middle is dropped, flag stays until next start
    start_sess(10'd5);
    send(tbl[0], 1'b0);
    send(v_illegal, 1'b0);
    send(tbl[1], 1'b1);
    wait_done(1'b1);
    chk("errIllegal_sticky", 32'(errIllegal), 32'd1);
    repeat (2) @(posedge clk);
    #1;
    chk("errIllegal_held_idle", 32'(errIllegal), 32'd1);

    // Illegal op carrying inLast still ends the session, no write
    start_sess(10'd0);
    send(v_illegal, 1'b1);
    chk("errIllegal_last", 32'(errIllegal), 32'd1);
    wait_done(1'b0);

    // Immediate overflow: truncated word written, flag depends on build
    start_sess(10'd0);
    send(v_range, 1'b1);
    wait_done(1'b1);
    chk("errRange_overflow", 32'(errRange), 32'(EXP_RANGE));
    start_sess(10'd0);
    chk("errRange_cleared", 32'(errRange), 32'd0);
    send(tbl[0], 1'b1);
    wait_done(1'b1);

    // Reset mid-session with buffered words
    imemReady = 1'b0;
    start_sess(10'h100);
    send(tbl[0], 1'b0);
    send(tbl[1], 1'b0);
    chk("pre_reset_we", 32'(imemWe), 32'd1);
    reset = 1'b0;
    #1;
    chk_reset_outputs();
    q.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    imemReady = 1'b1;
    @(posedge clk); #1;
    start_sess(10'd7);
    send(tbl[2], 1'b1);
    wait_done(1'b1);
    repeat (3) @(posedge clk);
    #1;
    chk("idle_no_write", 32'(imemWe), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
